// File: rtl/exec_control_pkg.sv
// Shared state encoding for the run/step/halt sequencer.
package exec_control_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_BREAK = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

endpackage

// File: rtl/exec_control_input_sync.sv
// Multi-flop synchronizer for an asynchronous board input.
// With EDGE set, the output is a one-cycle pulse on the synchronized rising edge instead of the level.
module exec_control_input_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE        = 1'b0
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;
  logic                   w_level;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_level = r_sync[SYNC_STAGES-1];
  assign o_sync  = EDGE ? (w_level & ~r_dly) : w_level;

endmodule

// File: rtl/exec_control.sv
// Run/step/halt sequencer: produces the datapath update enable, handles breakpoint and HALT,
// and counts executed instructions.
module exec_control
  import exec_control_pkg::*;
#(
  parameter int PC_WIDTH    = 6,
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_run_sw,
  input  logic                 i_step_btn,
  input  logic                 i_halt_instr,
  input  logic [PC_WIDTH-1:0]  i_pc_value,
  input  logic                 i_bp_enable,
  input  logic [PC_WIDTH-1:0]  i_bp_addr,
  output logic                 o_run,
  output logic [STATE_W-1:0]   o_state,
  output logic                 o_halted,
  output logic                 o_bp_hit,
  output logic [CNT_WIDTH-1:0] o_instr_count
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  r_bp_skip;
  logic [CNT_WIDTH-1:0]  r_instr_count;
  logic                  w_run_s;
  logic                  w_step_rise;
  logic                  w_bp_match;
  logic                  w_run;
  logic                  w_set_skip;

  exec_control_input_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE(1'b0)) u_run_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_async (i_run_sw),
    .o_sync  (w_run_s)
  );

  exec_control_input_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE(1'b1)) u_step_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_async (i_step_btn),
    .o_sync  (w_step_rise)
  );

  // bp_skip lets execution leave the breakpointed PC without re-triggering on it
  assign w_bp_match = i_bp_enable & (i_pc_value == i_bp_addr) & ~r_bp_skip;

  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    w_set_skip  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_run_s)          w_state_nxt = ST_RUN;
        else if (w_step_rise) w_state_nxt = ST_STEP;
      end
      ST_RUN: begin
        w_run = ~i_halt_instr & ~w_bp_match;
        if (i_halt_instr)    w_state_nxt = ST_HALT;
        else if (w_bp_match) w_state_nxt = ST_BREAK;
        else if (~w_run_s)   w_state_nxt = ST_IDLE;
      end
      ST_STEP: begin
        w_run       = ~i_halt_instr;
        w_state_nxt = i_halt_instr ? ST_HALT : ST_IDLE;
      end
      ST_BREAK: begin
        if (w_step_rise) begin
          w_state_nxt = ST_STEP;
          w_set_skip  = 1'b1;
        end else if (~w_run_s) begin
          w_state_nxt = ST_IDLE;
          w_set_skip  = 1'b1;
        end
      end
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_bp_skip <= 1'b0;
    end else if (w_run) begin
      r_bp_skip <= 1'b0;
    end else if (w_set_skip) begin
      r_bp_skip <= 1'b1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_instr_count <= '0;
    end else if (w_run && (r_instr_count != '1)) begin
      r_instr_count <= r_instr_count + 1'b1;
    end
  end

  assign o_run         = w_run;
  assign o_state       = r_state;
  assign o_halted      = (r_state == ST_HALT);
  assign o_bp_hit      = (r_state == ST_BREAK);
  assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_exec_control.sv
// Directed bench for exec_control: the bench plays the datapath PC register, advancing it on run.
module tb_exec_control;

  logic        clk;
  logic        rst;
  logic        run_sw;
  logic        step_btn;
  logic        halt_instr;
  logic        bp_enable;
  logic [5:0]  bp_addr;
  logic [5:0]  pc;
  logic        pc_load;
  logic [5:0]  pc_load_val;

  logic        run;
  logic [2:0]  state;
  logic        halted;
  logic        bp_hit;
  logic [15:0] cnt;

  logic        s_run;
  logic [2:0]  s_state;
  logic        s_halted;
  logic        s_bp_hit;
  logic [1:0]  s_cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic halt;
    logic bp_en;
    logic on_pc;
    logic exp_run;
  } vec_t;
  vec_t vecs [8];

  exec_control dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_run_sw      (run_sw),
    .i_step_btn    (step_btn),
    .i_halt_instr  (halt_instr),
    .i_pc_value    (pc),
    .i_bp_enable   (bp_enable),
    .i_bp_addr     (bp_addr),
    .o_run         (run),
    .o_state       (state),
    .o_halted      (halted),
    .o_bp_hit      (bp_hit),
    .o_instr_count (cnt)
  );

  // narrow counter copy to reach saturation within a few cycles
  exec_control #(.CNT_WIDTH(2)) u_sat (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_run_sw      (run_sw),
    .i_step_btn    (step_btn),
    .i_halt_instr  (halt_instr),
    .i_pc_value    (pc),
    .i_bp_enable   (bp_enable),
    .i_bp_addr     (bp_addr),
    .o_run         (s_run),
    .o_state       (s_state),
    .o_halted      (s_halted),
    .o_bp_hit      (s_bp_hit),
    .o_instr_count (s_cnt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (pc_load)  pc <= pc_load_val;
    else if (run) pc <= pc + 6'd1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    run_sw     = 1'b0;
    step_btn   = 1'b0;
    halt_instr = 1'b0;
    bp_enable  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic load_pc(input logic [5:0] v);
    pc_load_val = v;
    pc_load     = 1'b1;
    tick();
    pc_load     = 1'b0;
  endtask

  task automatic wait_pc(input logic [5:0] v, input int maxc, input string nm);
    for (int i = 0; i < maxc && pc != v; i++) tick();
    chk(nm, 32'(pc), 32'(v));
  endtask

  task automatic wait_state(input logic [2:0] v, input int maxc, input string nm);
    for (int i = 0; i < maxc && state != v; i++) tick();
    chk(nm, 32'(state), 32'(v));
  endtask

  task automatic press_step(input int hold);
    step_btn = 1'b1;
    repeat (hold) tick();
    step_btn = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; run_sw = 1'b0; step_btn = 1'b0; halt_instr = 1'b0;
    bp_enable = 1'b0; bp_addr = 6'd0; pc = 6'd0; pc_load = 1'b0; pc_load_val = 6'd0;

    // reset state
    repeat (10) tick();
    chk("rst_run", 32'(run), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", 32'(cnt), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_bp_hit", 32'(bp_hit), 32'd0);
    rst = 1'b0;
    tick();

    // free run from PC=32 and latency
    load_pc(6'd32);
    run_sw = 1'b1;
    tick();
    chk("lat_e1_run", 32'(run), 32'd0);
    tick();
    chk("lat_e2_run", 32'(run), 32'd0);
    tick();
    chk("lat_e3_run", 32'(run), 32'd1);
    chk("lat_e3_state", 32'(state), 32'd1);
    repeat (5) tick();
    chk("run5_count", 32'(cnt), 32'd5);
    chk("run5_pc", 32'(pc), 32'd37);
    chk("run5_sat_count", 32'(s_cnt), 32'd3);
    run_sw = 1'b0;
    repeat (3) tick();
    chk("stop_state", 32'(state), 32'd0);
    chk("stop_count", 32'(cnt), 32'd8);
    chk("stop_pc", 32'(pc), 32'd40);
    repeat (4) tick();
    chk("frozen_count", 32'(cnt), 32'd8);

    // async reset while running
    run_sw = 1'b1;
    wait_state(3'd1, 8, "rerun_state");
    chk("rerun_run", 32'(run), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_run", 32'(run), 32'd0);
    chk("async_rst_count", 32'(cnt), 32'd0);
    chk("async_rst_state", 32'(state), 32'd0);
    do_reset();

    // breakpoint at 35, single step off it, then resume
    load_pc(6'd32);
    bp_enable = 1'b1;
    bp_addr   = 6'd35;
    run_sw    = 1'b1;
    wait_pc(6'd35, 12, "bp_reach_pc");
    chk("bp_run", 32'(run), 32'd0);
    chk("bp_count", 32'(cnt), 32'd3);
    tick();
    chk("bp_state", 32'(state), 32'd3);
    chk("bp_hit", 32'(bp_hit), 32'd1);
    repeat (3) tick();
    chk("bp_hold_state", 32'(state), 32'd3);
    chk("bp_hold_pc", 32'(pc), 32'd35);
    step_btn = 1'b1;
    repeat (2) tick();
    chk("bp_step_wait", 32'(state), 32'd3);
    tick();
    chk("bp_step_state", 32'(state), 32'd2);
    chk("bp_step_run", 32'(run), 32'd1);
    tick();
    chk("bp_after_step_state", 32'(state), 32'd0);
    chk("bp_after_step_pc", 32'(pc), 32'd36);
    chk("bp_after_step_count", 32'(cnt), 32'd4);
    tick();
    chk("bp_resume_state", 32'(state), 32'd1);
    chk("bp_resume_run", 32'(run), 32'd1);
    step_btn = 1'b0;

    // run decode in RUN across halt/breakpoint combinations, all within one cycle
    for (int i = 0; i < 8; i++) begin
      halt_instr = vecs[i].halt;
      bp_enable  = vecs[i].bp_en;
      bp_addr    = vecs[i].on_pc ? pc : pc + 6'd9;
      #1;
      chk($sformatf("run_vec%0d", i), 32'(run), 32'(vecs[i].exp_run));
    end
    halt_instr = 1'b0;
    bp_enable  = 1'b0;
    tick();
    chk("vec_after_state", 32'(state), 32'd1);
    chk("vec_after_pc", 32'(pc), 32'd37);
    do_reset();

    // HALT at PC=40 is absorbing
    load_pc(6'd37);
    run_sw = 1'b1;
    wait_pc(6'd40, 12, "halt_reach_pc");
    halt_instr = 1'b1;
    #1;
    chk("halt_run", 32'(run), 32'd0);
    chk("halt_count", 32'(cnt), 32'd3);
    tick();
    chk("halt_state", 32'(state), 32'd4);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_pc", 32'(pc), 32'd40);
    halt_instr = 1'b0;
    run_sw = 1'b0;
    repeat (6) tick();
    press_step(4);
    run_sw = 1'b1;
    repeat (6) tick();
    chk("halt_stay_state", 32'(state), 32'd4);
    chk("halt_stay_run", 32'(run), 32'd0);
    chk("halt_stay_count", 32'(cnt), 32'd3);
    chk("halt_stay_pc", 32'(pc), 32'd40);
    rst = 1'b1;
    #1;
    chk("halt_rst_halted", 32'(halted), 32'd0);
    chk("halt_rst_state", 32'(state), 32'd0);
    do_reset();

    // held step button gives one step per press
    load_pc(6'd0);
    press_step(20);
    chk("step1_count", 32'(cnt), 32'd1);
    chk("step1_pc", 32'(pc), 32'd1);
    chk("step1_sat_count", 32'(s_cnt), 32'd1);
    chk("step1_state", 32'(state), 32'd0);
    press_step(20);
    press_step(20);
    chk("step3_count", 32'(cnt), 32'd3);
    chk("step3_pc", 32'(pc), 32'd3);
    chk("step3_state", 32'(state), 32'd0);
    do_reset();

    // counter saturation on the narrow instance
    load_pc(6'd0);
    run_sw = 1'b1;
    wait_state(3'd1, 8, "sat_run_state");
    repeat (2) tick();
    chk("sat_pre_count", 32'(s_cnt), 32'd2);
    chk("sat_pre_main", 32'(cnt), 32'd2);
    repeat (4) tick();
    chk("sat_count", 32'(s_cnt), 32'd3);
    chk("sat_main_count", 32'(cnt), 32'd6);
    run_sw = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
